// File: rtl/ddr_read_scoreboard.sv
// Read-data scoreboard for a DDR model: shadows write bursts, queues read commands,
// assembles returned beats and checks each completed burst against the shadow copy.
module ddr_read_scoreboard #(
    parameter int DQ_W     = 8,
    parameter int MAX_BL   = 8,
    parameter int ADDR_W   = 10,
    parameter int RQ_DEPTH = 8,
    parameter int CNT_W    = 16
) (
    input  logic                     clock_t,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DQ_W*MAX_BL-1:0]   wr_data,
    input  logic                     wr_bc4,
    input  logic                     rd_cmd_valid,
    input  logic [ADDR_W-1:0]        rd_cmd_addr,
    input  logic                     rd_cmd_bc4,
    output logic                     rd_cmd_ready,
    input  logic                     rd_beat_valid,
    input  logic [DQ_W-1:0]          rd_beat_data,
    output logic                     chk_valid,
    output logic [ADDR_W-1:0]        chk_addr,
    output logic [DQ_W*MAX_BL-1:0]   chk_exp,
    output logic [DQ_W*MAX_BL-1:0]   chk_got,
    output logic                     chk_pass,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         fail_cnt,
    output logic                     err_overflow,
    output logic                     err_orphan,
    output logic                     err_unwritten
);

    localparam int W      = DQ_W * MAX_BL;
    localparam int PTR_W  = $clog2(RQ_DEPTH);
    localparam int QC_W   = PTR_W + 1;
    localparam int BEAT_W = $clog2(MAX_BL);
    localparam int ENTRIES = 2 ** ADDR_W;
    localparam logic [W-1:0] LOW_MASK = {{(W/2){1'b0}}, {(W/2){1'b1}}};

    typedef enum logic {IDLE, COLLECT} state_t;

    logic [W-1:0]                 shadow [ENTRIES];
    logic [ENTRIES-1:0]           written;
    logic [ADDR_W-1:0]            q_addr [RQ_DEPTH];
    logic                         q_bc4  [RQ_DEPTH];
    logic [PTR_W-1:0]             wr_ptr, rd_ptr;
    logic [QC_W-1:0]              q_count;
    logic [MAX_BL-1:0][DQ_W-1:0]  lanes;
    logic [BEAT_W-1:0]            beat_cnt;
    state_t                       state;

    logic                         q_empty, q_full;
    logic [ADDR_W-1:0]            head_addr;
    logic                         head_bc4;
    logic [BEAT_W-1:0]            last_idx;
    logic                         beat_take, last_beat, push, pop;
    logic [MAX_BL-1:0][DQ_W-1:0]  asm_lanes;
    logic [W-1:0]                 got_word, exp_word;
    logic                         result_pass;

    assign q_empty      = (q_count == '0);
    assign q_full       = (q_count == QC_W'(RQ_DEPTH));
    assign rd_cmd_ready = !q_full;
    assign head_addr    = q_addr[rd_ptr];
    assign head_bc4     = q_bc4[rd_ptr];
    assign last_idx     = head_bc4 ? BEAT_W'(MAX_BL/2 - 1) : BEAT_W'(MAX_BL - 1);
    assign beat_take    = rd_beat_valid && !q_empty;
    assign last_beat    = beat_take && (beat_cnt == last_idx);
    assign pop          = last_beat;
    assign push         = rd_cmd_valid && (!q_full || pop);

    // The final beat is folded in combinationally so the check sees the complete burst.
    always_comb begin
        asm_lanes           = lanes;
        asm_lanes[beat_cnt] = rd_beat_data;
        got_word            = asm_lanes;
        exp_word            = shadow[head_addr];
        if (head_bc4) begin
            got_word = got_word & LOW_MASK;
            exp_word = exp_word & LOW_MASK;
        end
        result_pass = written[head_addr] && (got_word == exp_word);
    end

    // NOTE: storage arrays carry no reset; validity lives in written/q_count, which do.
    always_ff @(posedge clock_t) begin
        if (wr_valid) begin
            if (wr_bc4)
                shadow[wr_addr] <= {shadow[wr_addr][W-1:W/2], wr_data[W/2-1:0]};
            else
                shadow[wr_addr] <= wr_data;
        end
        if (push) begin
            q_addr[wr_ptr] <= rd_cmd_addr;
            q_bc4[wr_ptr]  <= rd_cmd_bc4;
        end
        if (beat_take)
            lanes[beat_cnt] <= rd_beat_data;
    end

    // NOTE: non-blocking updates mean a same-edge write to the checked index is not yet
    // visible to exp_word, so the comparison always uses the old shadow data.
    always_ff @(posedge clock_t) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            q_count       <= '0;
            state         <= IDLE;
            beat_cnt      <= '0;
            written       <= '0;
            chk_valid     <= 1'b0;
            chk_addr      <= '0;
            chk_exp       <= '0;
            chk_got       <= '0;
            chk_pass      <= 1'b0;
            pass_cnt      <= '0;
            fail_cnt      <= '0;
            err_overflow  <= 1'b0;
            err_orphan    <= 1'b0;
            err_unwritten <= 1'b0;
        end else begin
            if (wr_valid)
                written[wr_addr] <= 1'b1;

            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
            if (rd_cmd_valid && q_full && !pop)
                err_overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (rd_beat_valid && q_empty) begin
                        err_orphan <= 1'b1;
                    end else if (beat_take) begin
                        state    <= last_beat ? IDLE : COLLECT;
                        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                    end
                end
                COLLECT: begin
                    if (beat_take) begin
                        state    <= last_beat ? IDLE : COLLECT;
                        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end
            endcase

            chk_valid <= last_beat;
            if (last_beat) begin
                chk_addr <= head_addr;
                chk_exp  <= exp_word;
                chk_got  <= got_word;
                chk_pass <= result_pass;
                if (result_pass) begin
                    if (pass_cnt != '1)
                        pass_cnt <= pass_cnt + 1'b1;
                end else if (fail_cnt != '1) begin
                    fail_cnt <= fail_cnt + 1'b1;
                end
                if (!written[head_addr])
                    err_unwritten <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_read_scoreboard.sv
// Directed bench for ddr_read_scoreboard: inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle after the capturing edge.
module tb_ddr_read_scoreboard;

    logic         clock_t = 1'b0;
    logic         reset = 1'b1;
    logic         wr_valid = 1'b0;
    logic [9:0]   wr_addr = '0;
    logic [63:0]  wr_data = '0;
    logic         wr_bc4 = 1'b0;
    logic         rd_cmd_valid = 1'b0;
    logic [9:0]   rd_cmd_addr = '0;
    logic         rd_cmd_bc4 = 1'b0;
    logic         rd_cmd_ready;
    logic         rd_beat_valid = 1'b0;
    logic [7:0]   rd_beat_data = '0;
    logic         chk_valid;
    logic [9:0]   chk_addr;
    logic [63:0]  chk_exp;
    logic [63:0]  chk_got;
    logic         chk_pass;
    logic [15:0]  pass_cnt;
    logic [15:0]  fail_cnt;
    logic         err_overflow;
    logic         err_orphan;
    logic         err_unwritten;

    int errors = 0;
    int checks = 0;

    ddr_read_scoreboard dut (
        .clock_t       (clock_t),
        .reset         (reset),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_bc4        (wr_bc4),
        .rd_cmd_valid  (rd_cmd_valid),
        .rd_cmd_addr   (rd_cmd_addr),
        .rd_cmd_bc4    (rd_cmd_bc4),
        .rd_cmd_ready  (rd_cmd_ready),
        .rd_beat_valid (rd_beat_valid),
        .rd_beat_data  (rd_beat_data),
        .chk_valid     (chk_valid),
        .chk_addr      (chk_addr),
        .chk_exp       (chk_exp),
        .chk_got       (chk_got),
        .chk_pass      (chk_pass),
        .pass_cnt      (pass_cnt),
        .fail_cnt      (fail_cnt),
        .err_overflow  (err_overflow),
        .err_orphan    (err_orphan),
        .err_unwritten (err_unwritten)
    );

    initial forever #5 clock_t = ~clock_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock_t);
        @(negedge clock_t);
        reset = 1'b0;
    endtask

    task automatic write_burst(input logic [9:0] a, input logic [63:0] d, input logic bc4);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_bc4 = bc4;
        @(negedge clock_t);
        wr_valid = 1'b0; wr_bc4 = 1'b0;
    endtask

    task automatic read_cmd(input logic [9:0] a, input logic bc4);
        rd_cmd_valid = 1'b1; rd_cmd_addr = a; rd_cmd_bc4 = bc4;
        @(negedge clock_t);
        rd_cmd_valid = 1'b0; rd_cmd_bc4 = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d);
        rd_beat_valid = 1'b1; rd_beat_data = d;
        @(negedge clock_t);
        rd_beat_valid = 1'b0;
    endtask

    // Sends beats 0..n-1 of a word, low byte first.
    task automatic send_word(input logic [63:0] w, input int n);
        for (int j = 0; j < n; j++)
            send_beat(w[j*8 +: 8]);
    endtask

    initial begin
        int first_pulse;
        int second_pulse;
        int pulses;
        logic [63:0] w0;
        logic [63:0] w1;

        do_reset();
        check("rst_chk_valid", chk_valid, 0);
        check("rst_ready", rd_cmd_ready, 1);
        check("rst_pass_cnt", pass_cnt, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        check("rst_flags", {err_overflow, err_orphan, err_unwritten}, 0);
        check("rst_chk_exp", chk_exp, 0);

        // Basic BL8 pass.
        write_burst(10'h005, 64'h0706050403020100, 1'b0);
        read_cmd(10'h005, 1'b0);
        send_word(64'h0706050403020100, 7);
        check("bl8_no_early_pulse", chk_valid, 0);
        send_beat(8'h07);
        check("bl8_valid", chk_valid, 1);
        check("bl8_pass", chk_pass, 1);
        check("bl8_addr", chk_addr, 10'h005);
        check("bl8_got", chk_got, 64'h0706050403020100);
        check("bl8_exp", chk_exp, 64'h0706050403020100);
        check("bl8_pass_cnt", pass_cnt, 1);
        @(negedge clock_t);
        check("bl8_pulse_width", chk_valid, 0);

        // Corrupted beat 3.
        read_cmd(10'h005, 1'b0);
        send_word(64'h07060504FF020100, 8);
        check("bad_valid", chk_valid, 1);
        check("bad_pass", chk_pass, 0);
        check("bad_got", chk_got, 64'h07060504FF020100);
        check("bad_fail_cnt", fail_cnt, 1);
        check("bad_pass_cnt_hold", pass_cnt, 1);
        check("bad_no_unwritten", err_unwritten, 0);

        // BC4 write merges into lower half only; BL8 then BC4 read.
        write_burst(10'h010, 64'h1111111122222222, 1'b0);
        write_burst(10'h010, 64'h99999999AABBCCDD, 1'b1);
        read_cmd(10'h010, 1'b0);
        send_word(64'h11111111AABBCCDD, 8);
        check("bc4w_exp", chk_exp, 64'h11111111AABBCCDD);
        check("bc4w_pass", chk_pass, 1);
        read_cmd(10'h010, 1'b1);
        send_word(64'h00000000AABBCCDD, 3);
        check("bc4r_no_early_pulse", chk_valid, 0);
        send_beat(8'hAA);
        check("bc4r_valid", chk_valid, 1);
        check("bc4r_exp", chk_exp, 64'h00000000AABBCCDD);
        check("bc4r_got", chk_got, 64'h00000000AABBCCDD);
        check("bc4r_pass", chk_pass, 1);
        check("bc4r_pass_cnt", pass_cnt, 3);

        // Orphan beat, then read of a never-written entry.
        do_reset();
        send_beat(8'h55);
        check("orphan_flag", err_orphan, 1);
        check("orphan_no_pulse", chk_valid, 0);
        read_cmd(10'h3FF, 1'b0);
        send_word(64'h0, 8);
        check("unwr_valid", chk_valid, 1);
        check("unwr_pass", chk_pass, 0);
        check("unwr_flag", err_unwritten, 1);
        check("unwr_fail_cnt", fail_cnt, 1);
        check("unwr_addr", chk_addr, 10'h3FF);

        // Queue fill and overflow.
        do_reset();
        check("rst_clears_flags", {err_overflow, err_orphan, err_unwritten}, 0);
        for (int i = 0; i < 7; i++)
            read_cmd(10'(8'h20 + i), 1'b0);
        check("seven_ready", rd_cmd_ready, 1);
        read_cmd(10'h027, 1'b0);
        check("full_not_ready", rd_cmd_ready, 0);
        check("full_no_overflow", err_overflow, 0);
        read_cmd(10'h028, 1'b0);
        check("overflow_flag", err_overflow, 1);

        // Push on the cycle of a final pop while full.
        do_reset();
        for (int i = 0; i < 8; i++)
            read_cmd(10'(8'h20 + i), 1'b0);
        send_word(64'h0, 7);
        rd_cmd_valid = 1'b1; rd_cmd_addr = 10'h030;
        rd_beat_valid = 1'b1; rd_beat_data = 8'h00;
        @(negedge clock_t);
        rd_cmd_valid = 1'b0; rd_beat_valid = 1'b0;
        check("pushpop_pulse", chk_valid, 1);
        check("pushpop_addr", chk_addr, 10'h020);
        check("pushpop_no_overflow", err_overflow, 0);
        check("pushpop_still_full", rd_cmd_ready, 0);

        // Back-to-back BL8 bursts with no gap.
        do_reset();
        w0 = 64'h8877665544332211;
        w1 = 64'h0123456789ABCDEF;
        write_burst(10'h040, w0, 1'b0);
        write_burst(10'h041, w1, 1'b0);
        read_cmd(10'h040, 1'b0);
        read_cmd(10'h041, 1'b0);
        first_pulse = -1;
        second_pulse = -1;
        pulses = 0;
        for (int i = 0; i < 17; i++) begin
            if (i < 8)
                send_beat(w0[i*8 +: 8]);
            else if (i < 16)
                send_beat(w1[(i-8)*8 +: 8]);
            else
                @(negedge clock_t);
            if (chk_valid) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
                else second_pulse = i;
            end
        end
        check("b2b_pulses", 64'(pulses), 2);
        check("b2b_first", 64'(first_pulse), 7);
        check("b2b_spacing", 64'(second_pulse - first_pulse), 8);
        check("b2b_pass_cnt", pass_cnt, 2);
        check("b2b_fail_cnt", fail_cnt, 0);

        // Reset during beat 4 of a third burst.
        read_cmd(10'h040, 1'b0);
        send_word(w0, 4);
        rd_beat_valid = 1'b1; rd_beat_data = w0[39:32];
        reset = 1'b1;
        @(negedge clock_t);
        rd_beat_valid = 1'b0;
        reset = 1'b0;
        check("midrst_no_pulse", chk_valid, 0);
        check("midrst_pass_cnt", pass_cnt, 0);
        check("midrst_fail_cnt", fail_cnt, 0);
        check("midrst_ready", rd_cmd_ready, 1);
        @(negedge clock_t);
        check("midrst_still_no_pulse", chk_valid, 0);

        // Beat counter restarted: a fresh burst completes after exactly 8 beats.
        write_burst(10'h040, w0, 1'b0);
        read_cmd(10'h040, 1'b0);
        send_word(w0, 7);
        check("post_rst_no_early", chk_valid, 0);
        send_beat(w0[63:56]);
        check("post_rst_valid", chk_valid, 1);
        check("post_rst_pass", chk_pass, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr_read_scoreboard.md
Name: ddr_read_scoreboard

Overview:
- Parametrised successor to the DIMM memory checker.
- Keeps a shadow copy of every write burst, indexed by burst address.
- Queues outstanding read addresses in order and assembles the returned read beats (already deserialised, one beat per cycle).
- Compares each completed burst against the shadow copy and reports per-burst results, pass/fail counters and sticky error flags.
- Supports mixed BL8/BC4 traffic per transaction and sits beside the DDR4 controller in the testbench.

Parameters:
DQ_W, 8, bits per data beat
MAX_BL, 8, beats per full burst; burst word width W = DQ_W*MAX_BL
ADDR_W, 10, shadow-memory index width (2**ADDR_W entries)
RQ_DEPTH, 8, read-address queue depth (power of 2, >=2)
CNT_W, 16, pass/fail counter width

Ports:
clock_t  in  1  testbench clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
wr_valid  in  1  write burst captured this cycle
wr_addr  in  ADDR_W  write burst index
wr_data  in  W  write data; beat 0 in bits [DQ_W-1:0]
wr_bc4  in  1  1 = BC4 write: only beats 0..MAX_BL/2-1 are updated
rd_cmd_valid  in  1  read command issued
rd_cmd_addr  in  ADDR_W  read burst index
rd_cmd_bc4  in  1  1 = BC4 read
rd_cmd_ready  out  1  queue not full
rd_beat_valid  in  1  one read beat present
rd_beat_data  in  DQ_W  read beat
chk_valid  out  1  one-cycle result pulse
chk_addr  out  ADDR_W  checked index
chk_exp  out  W  expected word; BC4 upper half forced to 0
chk_got  out  W  assembled word; BC4 upper half forced to 0
chk_pass  out  1  exp==got and the entry was written
pass_cnt  out  CNT_W  saturating pass count
fail_cnt  out  CNT_W  saturating fail count
err_overflow  out  1  sticky: rd_cmd_valid while full and no pop that cycle
err_orphan  out  1  sticky: rd_beat_valid with the queue empty
err_unwritten  out  1  sticky: a read checked an entry never written since reset

Behaviour:
- Reset state: all outputs 0 except rd_cmd_ready=1. Reset clears queue pointers, occupancy, beat counter, per-entry written bits, counters and flags. Shadow data array need not be cleared.
- Reset mid-burst discards the partial burst; nothing is reported for it.
- Write path: on wr_valid, shadow[wr_addr] is updated next edge.
  - wr_bc4=1 updates only the lower W/2 bits and keeps the upper half.
  - Sets written[wr_addr].
- Read queue: FIFO of {addr, bc4}.
  - Push on rd_cmd_valid && (not full || pop this cycle); simultaneous push+pop when full is legal.
  - rd_cmd_ready = !full, combinational from occupancy.
  - A dropped push sets err_overflow.
- Beat FSM, two states:
  - IDLE: beat counter = 0.
    - rd_beat_valid with queue empty: set err_orphan, discard the beat, stay in IDLE.
    - Otherwise store the beat in lane 0 and go to COLLECT, or complete at once if burst length is 1.
  - COLLECT: each rd_beat_valid writes lane[cnt], then cnt++.
    - Burst length = MAX_BL/2 when the head entry has bc4, else MAX_BL.
    - The last beat pops the head and returns to IDLE (cnt = 0).
    - Cycles without beats hold state.
  - A beat on the cycle after a last beat starts the next burst; no gap is required.
- Check: evaluated on the last-beat edge against shadow contents before any same-cycle write to the same index (old data wins).
  - Results are registered, so chk_valid pulses exactly 1 cycle after the last beat.
  - BC4 compares the lower W/2 bits only.
  - chk_pass = written[addr] && match.
  - pass_cnt/fail_cnt increment on chk_valid and saturate at all-ones.
  - An unwritten entry counts as a fail and sets err_unwritten.
- Sticky flags clear only on reset.

Test Plan:
- Write addr 0x005 data 0x0706050403020100; read 0x005; beats 0x00..0x07 -> chk_valid on cycle after beat 7, chk_pass=1, pass_cnt=1.
- Same setup; beat 3 returned as 0xFF -> chk_pass=0, chk_got=0x07060504FF020100, fail_cnt=1.
- BC4 write of 0xAABBCCDD to 0x010 over a prior full write of 0x1111111122222222; BL8 read returns 0x11111111AABBCCDD -> pass; BC4 read returns 4 beats -> chk_exp=0x00000000AABBCCDD, pass.
- Issue RQ_DEPTH=8 reads with no beats -> rd_cmd_ready=0; 9th command with no pop -> err_overflow=1. Push on the cycle of a final pop -> accepted, occupancy stays 8.
- rd_beat_valid after reset with no reads queued -> err_orphan=1, no chk_valid. Read of an unwritten addr 0x3FF -> chk_pass=0, err_unwritten=1.
- Two BL8 reads back-to-back over 16 consecutive beats -> two chk_valid pulses 8 cycles apart. Assert reset at beat 4 of a third read -> no pulse; counters and queue are zero next cycle.
